timer_counter: RTL and testbench

- Memory-mapped 32-bit down-counting timer. Two instances sit directly downstream of the CPU-to-device bridge: TC0 at 0x0000_7F00–0x0000_7F0B and TC1 at 0x0000_7F10–0x0000_7F1B.
- The bridge presents word writes (it has already merged any partial byte or halfword data), selects the register with Addr[3:2], and routes IRQ into HWInt.
- The timer supports a one-shot mode and an auto-reload mode, with a maskable interrupt.

---
 rtl/timer_counter.sv | 151 +++++++++++++++
 tb/tb_timer_counter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped 32-bit down-counting timer with one-shot and
// auto-reload modes and a maskable interrupt.
//
// Ports:
//   clk    - system clock (only clock)
//   reset  - asynchronous, active-low reset
//   Addr   - register select (bus address bits [3:2])
//              0: CTRL   {28'b0, IM, MODE[1:0], EN}   R/W
//              1: PRESET initial count                R/W
//              2: COUNT  current count                RO
//              3: reads 0, writes ignored
//   WE     - write enable, sampled on the rising clk edge
//   Din    - full-word write data
//   Dout   - read data, combinational from Addr
//   IRQ    - interrupt request (CTRL.IM & irq_flag)
module timer_counter #(
    parameter int COUNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_RELOAD = 2'b01;

    state_t              state;
    state_t              state_nxt;

    logic                en;
    logic [1:0]          mode;
    logic                im;
    logic [COUNT_W-1:0]  preset;
    logic [COUNT_W-1:0]  count;
    logic                irq_flag;

    logic                wr_ctrl;
    logic                wr_preset;
    logic                auto_reload;
    logic                count_done;

    // Decrement that stops at zero; a count of 0 or 1 both land on 0, which
    // is what makes PRESET=0 and PRESET=1 behave the same.
    function automatic logic [COUNT_W-1:0] dec_sat(input logic [COUNT_W-1:0] v);
        return (v == '0) ? '0 : v - COUNT_W'(1);
    endfunction

    assign wr_ctrl     = WE && (Addr == 2'd0);
    assign wr_preset   = WE && (Addr == 2'd1);
    // MODE values 10/11 fall back to one-shot.
    assign auto_reload = (mode == MODE_RELOAD);
    assign count_done  = (count <= COUNT_W'(1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: state_nxt = CNT;
            CNT: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (count_done) begin
                    state_nxt = INT;
                end
            end
            INT: state_nxt = (auto_reload && en) ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Register file, counter and interrupt flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en       <= 1'b0;
            mode     <= 2'b00;
            im       <= 1'b0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            // A bus write to CTRL overrides the one-shot auto-clear of EN.
            if (wr_ctrl) begin
                en   <= Din[0];
                mode <= Din[2:1];
                im   <= Din[3];
            end else if (state == INT && !auto_reload) begin
                en <= 1'b0;
            end

            if (wr_preset) begin
                preset <= Din[COUNT_W-1:0];
            end

            case (state)
                LOAD: count <= preset;
                CNT: begin
                    if (en) begin
                        count <= dec_sat(count);
                    end
                end
                default: ;
            endcase

            // Setting from INT beats clearing by a bus write. In auto-reload
            // the flag self-clears one cycle later; in one-shot it is sticky
            // until software writes CTRL or PRESET.
            if (state == INT) begin
                irq_flag <= 1'b1;
            end else if (wr_ctrl || wr_preset || auto_reload) begin
                irq_flag <= 1'b0;
            end
        end
    end

    // Bus read mux and interrupt output
    always_comb begin
        Dout = '0;
        case (Addr)
            2'd0:    Dout = {28'd0, im, mode, en};
            2'd1:    Dout = 32'(preset);
            2'd2:    Dout = 32'(count);
            default: Dout = '0;
        endcase
        IRQ = im & irq_flag;
    end

endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: directed-vector bench for timer_counter with a
// cycle-level reference model and per-cycle output comparison.
module tb_timer_counter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  Addr = 2'd0;
    logic        WE = 1'b0;
    logic [31:0] Din = 32'd0;
    logic [31:0] Dout;
    logic        IRQ;

    int total = 0;
    int bad   = 0;

    timer_counter #(.COUNT_W(32)) dut (
        .clk  (clk),
        .reset(reset),
        .Addr (Addr),
        .WE   (WE),
        .Din  (Din),
        .Dout (Dout),
        .IRQ  (IRQ)
    );

    always #5 clk = ~clk;

    // Reference model. The timer's life is a sequence of slots:
    // m_pos = -1 idle, 0 the load slot, 1..m_len the counting slots,
    // m_len+1 the firing slot. m_len = max(captured preset, 1); the count
    // shown after counting slot j is captured_preset - j, floored at 0.
    logic        m_en = 1'b0;
    logic [1:0]  m_mode = 2'b00;
    logic        m_im = 1'b0;
    logic [31:0] m_preset = 32'd0;
    logic [31:0] m_count = 32'd0;
    logic        m_flag = 1'b0;
    int          m_pos = -1;
    longint      m_len = 1;
    longint      m_base = 0;

    always @(posedge clk or negedge reset) begin : model
        logic        wc, wp, reload, fire, clr_en, n_flag, n_en;
        logic [1:0]  n_mode;
        logic        n_im;
        logic [31:0] n_count, n_preset;
        int          n_pos;
        longint      n_len, n_base;
        if (!reset) begin
            m_en <= 1'b0; m_mode <= 2'b00; m_im <= 1'b0;
            m_preset <= 32'd0; m_count <= 32'd0; m_flag <= 1'b0;
            m_pos <= -1; m_len <= 1; m_base <= 0;
        end else begin
            wc = WE && (Addr == 2'd0);
            wp = WE && (Addr == 2'd1);
            reload = (m_mode == 2'b01);
            fire = (m_pos == m_len + 1);
            clr_en = 1'b0;
            n_pos = m_pos; n_count = m_count; n_len = m_len; n_base = m_base;
            n_flag = m_flag;
            if (m_pos < 0) begin
                if (m_en) n_pos = 0;
            end else if (m_pos == 0) begin
                n_base = longint'(m_preset);
                n_len = (m_preset == 32'd0) ? 1 : longint'(m_preset);
                n_count = m_preset;
                n_pos = 1;
            end else if (!fire) begin
                if (!m_en) begin
                    n_pos = -1;
                end else begin
                    n_count = (m_pos < m_len) ? 32'(m_base - m_pos) : 32'd0;
                    n_pos = m_pos + 1;
                end
            end else begin
                if (reload) begin
                    n_pos = m_en ? 0 : -1;
                end else begin
                    n_pos = -1;
                    clr_en = 1'b1;
                end
            end
            if (fire) n_flag = 1'b1;
            else if (wc || wp || reload) n_flag = 1'b0;
            n_en = m_en; n_mode = m_mode; n_im = m_im;
            if (wc) begin
                n_en = Din[0]; n_mode = Din[2:1]; n_im = Din[3];
            end else if (clr_en) begin
                n_en = 1'b0;
            end
            n_preset = wp ? Din : m_preset;
            m_en <= n_en; m_mode <= n_mode; m_im <= n_im;
            m_preset <= n_preset; m_count <= n_count; m_flag <= n_flag;
            m_pos <= n_pos; m_len <= n_len; m_base <= n_base;
        end
    end

    function automatic logic [31:0] model_dout(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_im, m_mode, m_en};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        total++;
        if (Dout !== model_dout(Addr)) begin
            bad++;
            $display("FAIL model_dout addr=%0d got=%h exp=%h t=%0t", Addr, Dout, model_dout(Addr), $time);
        end
        total++;
        if (IRQ !== (m_im & m_flag)) begin
            bad++;
            $display("FAIL model_irq got=%b exp=%b t=%0t", IRQ, m_im & m_flag, $time);
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr = a; Din = d; WE = 1'b1;
        tick();
        WE = 1'b0;
    endtask

    task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp, input string nm);
        Addr = a;
        #1;
        chk(nm, Dout, exp);
    endtask

    // Records IRQ-high cycles and checks their spacing and number.
    task automatic measure(input int ncyc, input int period, input string nm);
        int last;
        int npulse;
        last = -1;
        npulse = 0;
        for (int i = 1; i <= ncyc; i++) begin
            tick();
            if (IRQ) begin
                if (last >= 0) chk(nm, 32'(i - last), 32'(period));
                last = i;
                npulse++;
            end
        end
        chk({nm, "_npulse_ge4"}, 32'(npulse >= 4), 32'd1);
    endtask

    initial begin : safety
        #200000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin : stim
        // Reset and readback
        repeat (2) tick();
        for (int a = 0; a < 4; a++) begin
            rd_chk(2'(a), 32'd0, "reset_rd");
            tick();
        end
        chk("reset_irq", 32'(IRQ), 32'd0);
        reset = 1'b1;
        for (int a = 0; a < 4; a++) begin
            rd_chk(2'(a), 32'd0, "post_reset_rd");
            tick();
        end

        // Preset / CTRL readback, read-only COUNT, unused address
        wr(2'd1, 32'hFFFF_FFFF);
        rd_chk(2'd1, 32'hFFFF_FFFF, "preset_rb");
        wr(2'd0, 32'hFFFF_FFFF);
        rd_chk(2'd0, 32'h0000_000F, "ctrl_rb");
        wr(2'd0, 32'h0);
        wr(2'd2, 32'h0000_1234);
        rd_chk(2'd2, 32'hFFFF_FFFF, "count_ro");
        wr(2'd3, 32'hDEAD_BEEF);
        rd_chk(2'd3, 32'd0, "addr3_rd");
        repeat (4) tick();

        // One-shot
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        Addr = 2'd2;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            rd_chk(2'd2, 32'(5 - i), "oneshot_count");
            tick();
        end
        rd_chk(2'd2, 32'd0, "oneshot_zero");
        chk("oneshot_irq_int", 32'(IRQ), 32'd0);
        tick();
        chk("oneshot_irq_rise", 32'(IRQ), 32'd1);
        rd_chk(2'd0, 32'h8, "oneshot_en_clr");
        repeat (3) tick();
        chk("oneshot_irq_hold", 32'(IRQ), 32'd1);
        wr(2'd1, 32'd5);
        chk("oneshot_irq_ack", 32'(IRQ), 32'd0);
        repeat (4) tick();

        // Auto-reload, PRESET=3 -> period 5
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        measure(30, 5, "reload_p3_period");
        wr(2'd0, 32'h0);
        repeat (4) tick();

        // Masked interrupt
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mask_irq", 32'(IRQ), 32'd0);
        end
        rd_chk(2'd2, 32'd0, "mask_count_zero");
        rd_chk(2'd0, 32'd0, "mask_en_clr");
        repeat (2) tick();

        // Pause and restart
        wr(2'd1, 32'd20);
        wr(2'd0, 32'h1);
        repeat (5) tick();
        rd_chk(2'd2, 32'd17, "pause_before");
        wr(2'd0, 32'h0);
        rd_chk(2'd2, 32'd16, "pause_freeze0");
        for (int i = 0; i < 10; i++) begin
            tick();
            rd_chk(2'd2, 32'd16, "pause_freeze");
        end
        wr(2'd0, 32'h1);
        tick();
        tick();
        rd_chk(2'd2, 32'd20, "pause_reload");
        wr(2'd0, 32'h0);
        repeat (4) tick();

        // Auto-reload with PRESET=0 -> period 3
        wr(2'd1, 32'd0);
        wr(2'd0, 32'hB);
        measure(20, 3, "reload_p0_period");
        wr(2'd0, 32'h0);
        repeat (4) tick();

        // Reset mid-count at COUNT=7
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        repeat (5) tick();
        rd_chk(2'd2, 32'd7, "midrst_before");
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_count", Dout, 32'd0);
        chk("midrst_irq", 32'(IRQ), 32'd0);
        rd_chk(2'd0, 32'd0, "midrst_ctrl");
        repeat (2) tick();
        reset = 1'b1;
        wr(2'd1, 32'd4);
        repeat (4) tick();
        rd_chk(2'd2, 32'd0, "midrst_idle_count");
        rd_chk(2'd0, 32'd0, "midrst_idle_ctrl");
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
